// File: rtl/legv8_ctrl_pkg.sv
// Shared encodings for the LEGv8 multi-cycle control unit: opcode match patterns,
// ALU/sign-extend codes, FSM states and the decoded control bundle.
package legv8_ctrl_pkg;

    localparam int unsigned OPC_W = 11;
    localparam int unsigned AOP_W = 4;

    // casez patterns; '?' bits belong to immediate/register fields
    localparam logic [OPC_W-1:0] OPCODE_ANDREG = 11'b10001010000;
    localparam logic [OPC_W-1:0] OPCODE_ORRREG = 11'b10101010000;
    localparam logic [OPC_W-1:0] OPCODE_ADDREG = 11'b10001011000;
    localparam logic [OPC_W-1:0] OPCODE_SUBREG = 11'b11001011000;
    localparam logic [OPC_W-1:0] OPCODE_ADDIMM = 11'b1001000100?;
    localparam logic [OPC_W-1:0] OPCODE_SUBIMM = 11'b1101000100?;
    localparam logic [OPC_W-1:0] OPCODE_MOVZ   = 11'b110100101??;
    localparam logic [OPC_W-1:0] OPCODE_B      = 11'b000101?????;
    localparam logic [OPC_W-1:0] OPCODE_CBZ    = 11'b10110100???;
    localparam logic [OPC_W-1:0] OPCODE_LDUR   = 11'b11111000010;
    localparam logic [OPC_W-1:0] OPCODE_STUR   = 11'b11111000000;

    localparam logic [AOP_W-1:0] ALUOP_AND   = 4'b0000;
    localparam logic [AOP_W-1:0] ALUOP_ORR   = 4'b0001;
    localparam logic [AOP_W-1:0] ALUOP_ADD   = 4'b0010;
    localparam logic [AOP_W-1:0] ALUOP_SUB   = 4'b0110;
    localparam logic [AOP_W-1:0] ALUOP_PASSB = 4'b0111;

    localparam logic [1:0] SIGNOP_I  = 2'b00;
    localparam logic [1:0] SIGNOP_D  = 2'b01;
    localparam logic [1:0] SIGNOP_B  = 2'b10;
    localparam logic [1:0] SIGNOP_CB = 2'b11;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_B,
        CLS_CBZ,
        CLS_LOAD,
        CLS_STORE
    } op_class_e;

    typedef struct packed {
        op_class_e        cls;
        logic             reg2loc;
        logic             alusrc;
        logic             mem2reg;
        logic [AOP_W-1:0] aluop;
        logic [1:0]       signop;
        logic             illegal;
    } ctrl_t;

endpackage

// File: rtl/legv8_decode.sv
// Combinational opcode decoder: maps an 11-bit LEGv8 opcode to its instruction
// class and datapath control fields. Unused fields stay 0.
module legv8_decode
    import legv8_ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] op,
    output ctrl_t            ctrl
);

    always_comb begin
        ctrl     = '0;
        ctrl.cls = CLS_ALU;
        casez (op)
            OPCODE_ANDREG: ctrl.aluop = ALUOP_AND;
            OPCODE_ORRREG: ctrl.aluop = ALUOP_ORR;
            OPCODE_ADDREG: ctrl.aluop = ALUOP_ADD;
            OPCODE_SUBREG: ctrl.aluop = ALUOP_SUB;
            OPCODE_ADDIMM: begin
                ctrl.alusrc = 1'b1;
                ctrl.aluop  = ALUOP_ADD;
                ctrl.signop = SIGNOP_I;
            end
            OPCODE_SUBIMM: begin
                ctrl.alusrc = 1'b1;
                ctrl.aluop  = ALUOP_SUB;
                ctrl.signop = SIGNOP_I;
            end
            OPCODE_MOVZ: begin
                ctrl.alusrc = 1'b1;
                ctrl.aluop  = ALUOP_PASSB;
            end
            OPCODE_B: begin
                ctrl.cls    = CLS_B;
                ctrl.signop = SIGNOP_B;
            end
            OPCODE_CBZ: begin
                ctrl.cls     = CLS_CBZ;
                ctrl.reg2loc = 1'b1;
                ctrl.aluop   = ALUOP_PASSB;
                ctrl.signop  = SIGNOP_CB;
            end
            OPCODE_LDUR: begin
                ctrl.cls     = CLS_LOAD;
                ctrl.alusrc  = 1'b1;
                ctrl.mem2reg = 1'b1;
                ctrl.aluop   = ALUOP_ADD;
                ctrl.signop  = SIGNOP_D;
            end
            OPCODE_STUR: begin
                ctrl.cls     = CLS_STORE;
                ctrl.reg2loc = 1'b1;
                ctrl.alusrc  = 1'b1;
                ctrl.aluop   = ALUOP_ADD;
                ctrl.signop  = SIGNOP_D;
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 control FSM (FETCH/DECODE/EXEC/MEM/WB) with memory handshakes,
// a wait-cycle timeout that raises a sticky bus_error, and illegal-opcode flagging.
module multicycle_control
    import legv8_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W    = 11,
    parameter int unsigned ALUOP_W     = 4,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                alu_zero,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    output logic                imem_req,
    output logic                ir_write,
    output logic                reg2loc,
    output logic                alusrc,
    output logic                mem2reg,
    output logic                regwrite,
    output logic                memread,
    output logic                memwrite,
    output logic [ALUOP_W-1:0]  aluop,
    output logic [1:0]          signop,
    output logic                pc_write,
    output logic                pc_src,
    output logic                instr_done,
    output logic                illegal_op,
    output logic                bus_error
);

    localparam int unsigned CTR_W = $clog2(MEM_TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [OPCODE_W-1:0] op_q, dec_op;
    logic [CTR_W-1:0]    ctr_q, ctr_d;
    logic                bus_error_q, bus_error_d;
    logic                limit;
    ctrl_t               ctrl;

    // DECODE must flag illegal opcodes before op_q has captured them
    assign dec_op = (state_q == DECODE) ? opcode : op_q;
    assign limit  = (ctr_q == CTR_W'(MEM_TIMEOUT - 1));
    assign bus_error = bus_error_q;

    legv8_decode u_decode (
        .op   (dec_op),
        .ctrl (ctrl)
    );

    always_comb begin
        state_d     = state_q;
        ctr_d       = '0;
        bus_error_d = bus_error_q;
        imem_req    = 1'b0;
        ir_write    = 1'b0;
        reg2loc     = 1'b0;
        alusrc      = 1'b0;
        mem2reg     = 1'b0;
        regwrite    = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        aluop       = '0;
        signop      = '0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        // Outputs stay quiet during reset so an aborted access never strobes
        if (!reset) begin
            if (state_q inside {EXEC, MEM, WB}) begin
                reg2loc = ctrl.reg2loc;
                alusrc  = ctrl.alusrc;
                mem2reg = ctrl.mem2reg;
                aluop   = ALUOP_W'(ctrl.aluop);
                signop  = ctrl.signop;
            end
            case (state_q)
                FETCH: begin
                    if (!bus_error_q) begin
                        imem_req = 1'b1;
                        if (imem_ready) begin
                            ir_write = 1'b1;
                            state_d  = DECODE;
                        end else if (limit) begin
                            bus_error_d = 1'b1;
                        end else begin
                            ctr_d = ctr_q + 1'b1;
                        end
                    end
                end
                DECODE: begin
                    if (ctrl.illegal) begin
                        illegal_op = 1'b1;
                        pc_write   = 1'b1;
                        instr_done = 1'b1;
                        state_d    = FETCH;
                    end else begin
                        state_d = EXEC;
                    end
                end
                EXEC: begin
                    unique case (ctrl.cls)
                        CLS_B, CLS_CBZ: begin
                            pc_write   = 1'b1;
                            pc_src     = (ctrl.cls == CLS_B) ? 1'b1 : alu_zero;
                            instr_done = 1'b1;
                            state_d    = FETCH;
                        end
                        CLS_LOAD, CLS_STORE: state_d = MEM;
                        default:             state_d = WB;
                    endcase
                end
                MEM: begin
                    memread  = (ctrl.cls == CLS_LOAD);
                    memwrite = (ctrl.cls == CLS_STORE);
                    if (dmem_ready) begin
                        if (ctrl.cls == CLS_LOAD) begin
                            state_d = WB;
                        end else begin
                            pc_write   = 1'b1;
                            instr_done = 1'b1;
                            state_d    = FETCH;
                        end
                    end else if (limit) begin
                        bus_error_d = 1'b1;
                        state_d     = FETCH;
                    end else begin
                        ctr_d = ctr_q + 1'b1;
                    end
                end
                WB: begin
                    regwrite   = 1'b1;
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= FETCH;
            op_q        <= '0;
            ctr_q       <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            bus_error_q <= bus_error_d;
            if (state_q == DECODE) begin
                op_q <= opcode;
            end
        end
    end

endmodule
